// File: rtl/inst_fetch_responder.sv
// Bus-side instruction fetch responder: takes one fetch request, reads the word over a
// valid/ack memory port and returns it with a single-cycle ReadShakeHands pulse.
module inst_fetch_responder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  FetchReady,
  input  logic [ADDR_WIDTH-1:0] FetchAddr,
  input  logic                  Flush,
  output logic                  ReadShakeHands,
  output logic [DATA_WIDTH-1:0] InstOut,
  output logic [ADDR_WIDTH-1:0] InstAddrOut,
  output logic                  FetchErr,
  output logic                  InstDiscard,
  output logic                  ProtocolErr,
  output logic                  Busy,
  output logic [CNT_WIDTH-1:0]  FetchCnt,
  output logic                  MemReq,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  input  logic                  MemAck,
  input  logic [DATA_WIDTH-1:0] MemRData
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MEM  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]            state_r;
  logic [TW-1:0]         tcnt_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  discard_r;
  logic                  rsh_r;
  logic [DATA_WIDTH-1:0] inst_r;
  logic [ADDR_WIDTH-1:0] inst_addr_r;
  logic                  err_r;
  logic                  disc_out_r;
  logic                  perr_r;
  logic [CNT_WIDTH-1:0]  cnt_r;
  logic                  mem_req_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;

  // Fetch sequencer: one outstanding request, response fields valid only in the pulse cycle.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_r     <= ST_IDLE;
      tcnt_r      <= '0;
      addr_r      <= '0;
      discard_r   <= 1'b0;
      rsh_r       <= 1'b0;
      inst_r      <= '0;
      inst_addr_r <= '0;
      err_r       <= 1'b0;
      disc_out_r  <= 1'b0;
      perr_r      <= 1'b0;
      cnt_r       <= '0;
      mem_req_r   <= 1'b0;
      mem_addr_r  <= '0;
    end else begin
      rsh_r       <= 1'b0;
      inst_r      <= '0;
      inst_addr_r <= '0;
      err_r       <= 1'b0;
      disc_out_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (FetchReady) begin
            addr_r    <= FetchAddr;
            discard_r <= Flush;
            tcnt_r    <= '0;
            if (FetchAddr[1:0] != 2'b00) begin
              state_r     <= ST_RESP;
              rsh_r       <= 1'b1;
              inst_addr_r <= FetchAddr;
              err_r       <= 1'b1;
              disc_out_r  <= Flush;
              cnt_r       <= cnt_r + CNT_WIDTH'(1);
            end else begin
              state_r    <= ST_MEM;
              mem_req_r  <= 1'b1;
              mem_addr_r <= FetchAddr;
            end
          end
        end
        ST_MEM: begin
          if (FetchReady) begin
            perr_r <= 1'b1;
          end
          discard_r <= discard_r | Flush;
          if (MemAck || (tcnt_r == TO_LAST)) begin
            // Ack wins over a coincident timeout; a timed-out fetch returns zero data.
            state_r     <= ST_RESP;
            mem_req_r   <= 1'b0;
            mem_addr_r  <= '0;
            tcnt_r      <= '0;
            rsh_r       <= 1'b1;
            inst_r      <= MemAck ? MemRData : '0;
            inst_addr_r <= addr_r;
            err_r       <= ~MemAck;
            disc_out_r  <= discard_r | Flush;
            cnt_r       <= cnt_r + CNT_WIDTH'(1);
          end else begin
            tcnt_r <= tcnt_r + TW'(1);
          end
        end
        ST_RESP: begin
          if (FetchReady) begin
            perr_r <= 1'b1;
          end
          state_r <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign ReadShakeHands = rsh_r;
  assign InstOut        = inst_r;
  assign InstAddrOut    = inst_addr_r;
  assign FetchErr       = err_r;
  // A Flush landing in the pulse cycle itself still marks that response.
  assign InstDiscard    = disc_out_r | (rsh_r & Flush);
  assign ProtocolErr    = perr_r;
  assign Busy           = (state_r != ST_IDLE);
  assign FetchCnt       = cnt_r;
  assign MemReq         = mem_req_r;
  assign MemAddr        = mem_addr_r;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench for inst_fetch_responder: default instance plus a short-timeout, 2-bit counter instance.
module tb_inst_fetch_responder;

  logic        Clk;
  logic        Rst;
  logic        a_fr, a_flush, a_ack;
  logic [31:0] a_faddr, a_rdata;
  logic        a_rsh, a_err, a_disc, a_perr, a_busy, a_mreq;
  logic [31:0] a_inst, a_iaddr, a_maddr;
  logic [15:0] a_cnt;

  logic        b_fr, b_flush, b_ack;
  logic [31:0] b_faddr, b_rdata;
  logic        b_rsh, b_err, b_disc, b_perr, b_busy, b_mreq;
  logic [31:0] b_inst, b_iaddr, b_maddr;
  logic [1:0]  b_cnt;

  int total;
  int bad;

  inst_fetch_responder dut_a (
    .Clk(Clk), .Rst(Rst), .FetchReady(a_fr), .FetchAddr(a_faddr), .Flush(a_flush),
    .ReadShakeHands(a_rsh), .InstOut(a_inst), .InstAddrOut(a_iaddr), .FetchErr(a_err),
    .InstDiscard(a_disc), .ProtocolErr(a_perr), .Busy(a_busy), .FetchCnt(a_cnt),
    .MemReq(a_mreq), .MemAddr(a_maddr), .MemAck(a_ack), .MemRData(a_rdata)
  );

  inst_fetch_responder #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(2)) dut_b (
    .Clk(Clk), .Rst(Rst), .FetchReady(b_fr), .FetchAddr(b_faddr), .Flush(b_flush),
    .ReadShakeHands(b_rsh), .InstOut(b_inst), .InstAddrOut(b_iaddr), .FetchErr(b_err),
    .InstDiscard(b_disc), .ProtocolErr(b_perr), .Busy(b_busy), .FetchCnt(b_cnt),
    .MemReq(b_mreq), .MemAddr(b_maddr), .MemAck(b_ack), .MemRData(b_rdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    total = 0; bad = 0;
    Rst = 1'b0;
    a_fr = 1'b0; a_flush = 1'b0; a_ack = 1'b0; a_faddr = 32'h0; a_rdata = 32'h0;
    b_fr = 1'b0; b_flush = 1'b0; b_ack = 1'b0; b_faddr = 32'h0; b_rdata = 32'h0;
    repeat (3) tick();
    check_eq("rst_rsh", {63'd0, a_rsh}, 64'd0);
    check_eq("rst_mreq", {63'd0, a_mreq}, 64'd0);
    check_eq("rst_busy", {63'd0, a_busy}, 64'd0);
    check_eq("rst_cnt", {48'd0, a_cnt}, 64'd0);
    Rst = 1'b1;
    tick();

    // aligned fetch, ack in the first MemReq cycle
    a_fr = 1'b1; a_faddr = 32'h8000_0000; a_ack = 1'b1; a_rdata = 32'h0000_0013;
    tick();
    a_fr = 1'b0;
    check_eq("t1_mreq", {63'd0, a_mreq}, 64'd1);
    check_eq("t1_maddr", {32'd0, a_maddr}, 64'h8000_0000);
    check_eq("t1_rsh_early", {63'd0, a_rsh}, 64'd0);
    tick();
    a_ack = 1'b0;
    check_eq("t1_rsh", {63'd0, a_rsh}, 64'd1);
    check_eq("t1_inst", {32'd0, a_inst}, 64'h13);
    check_eq("t1_iaddr", {32'd0, a_iaddr}, 64'h8000_0000);
    check_eq("t1_err", {63'd0, a_err}, 64'd0);
    check_eq("t1_cnt", {48'd0, a_cnt}, 64'd1);
    tick();
    check_eq("t1_rsh_off", {63'd0, a_rsh}, 64'd0);
    check_eq("t1_inst_off", {32'd0, a_inst}, 64'd0);
    check_eq("t1_busy_off", {63'd0, a_busy}, 64'd0);

    // ack delayed by 5 cycles
    a_fr = 1'b1; a_faddr = 32'h8000_0004; a_rdata = 32'hDEAD_BEEF;
    for (int i = 1; i <= 6; i++) begin
      tick();
      a_fr = 1'b0;
      check_eq("t2_mreq", {63'd0, a_mreq}, 64'd1);
      check_eq("t2_maddr", {32'd0, a_maddr}, 64'h8000_0004);
      check_eq("t2_rsh_wait", {63'd0, a_rsh}, 64'd0);
      if (i == 6) a_ack = 1'b1;
    end
    tick();
    a_ack = 1'b0;
    check_eq("t2_rsh", {63'd0, a_rsh}, 64'd1);
    check_eq("t2_inst", {32'd0, a_inst}, 64'hDEAD_BEEF);
    check_eq("t2_err", {63'd0, a_err}, 64'd0);
    check_eq("t2_cnt", {48'd0, a_cnt}, 64'd2);
    check_eq("t2_mreq_off", {63'd0, a_mreq}, 64'd0);
    tick();

    // misaligned fetch: no memory access, immediate error response
    a_fr = 1'b1; a_faddr = 32'h8000_0002;
    tick();
    a_fr = 1'b0;
    check_eq("t3_rsh", {63'd0, a_rsh}, 64'd1);
    check_eq("t3_err", {63'd0, a_err}, 64'd1);
    check_eq("t3_inst", {32'd0, a_inst}, 64'd0);
    check_eq("t3_iaddr", {32'd0, a_iaddr}, 64'h8000_0002);
    check_eq("t3_mreq", {63'd0, a_mreq}, 64'd0);
    check_eq("t3_cnt", {48'd0, a_cnt}, 64'd3);
    tick();
    check_eq("t3_err_off", {63'd0, a_err}, 64'd0);

    // flush mid-wait plus a protocol violation
    check_eq("t4_perr_pre", {63'd0, a_perr}, 64'd0);
    a_fr = 1'b1; a_faddr = 32'h8000_0008; a_rdata = 32'h00A0_0093;
    for (int i = 1; i <= 6; i++) begin
      tick();
      a_fr = 1'b0;
      a_flush = 1'b0;
      check_eq("t4_mreq", {63'd0, a_mreq}, 64'd1);
      check_eq("t4_maddr", {32'd0, a_maddr}, 64'h8000_0008);
      if (i == 2) a_flush = 1'b1;
      if (i == 4) begin
        a_fr = 1'b1; a_faddr = 32'h8000_0100;
      end
      if (i == 6) a_ack = 1'b1;
    end
    tick();
    a_ack = 1'b0;
    check_eq("t4_rsh", {63'd0, a_rsh}, 64'd1);
    check_eq("t4_inst", {32'd0, a_inst}, 64'h00A0_0093);
    check_eq("t4_iaddr", {32'd0, a_iaddr}, 64'h8000_0008);
    check_eq("t4_disc", {63'd0, a_disc}, 64'd1);
    check_eq("t4_perr", {63'd0, a_perr}, 64'd1);
    tick();
    check_eq("t4_mreq_after", {63'd0, a_mreq}, 64'd0);
    check_eq("t4_disc_off", {63'd0, a_disc}, 64'd0);
    check_eq("t4_perr_sticky", {63'd0, a_perr}, 64'd1);
    check_eq("t4_cnt", {48'd0, a_cnt}, 64'd4);

    // reset in the middle of a memory wait
    a_fr = 1'b1; a_faddr = 32'h8000_0010;
    tick();
    a_fr = 1'b0;
    check_eq("t5_mreq", {63'd0, a_mreq}, 64'd1);
    Rst = 1'b0;
    tick();
    Rst = 1'b1;
    a_ack = 1'b1; a_rdata = 32'h1234_5678;
    check_eq("t5_mreq_rst", {63'd0, a_mreq}, 64'd0);
    check_eq("t5_maddr_rst", {32'd0, a_maddr}, 64'd0);
    check_eq("t5_busy_rst", {63'd0, a_busy}, 64'd0);
    check_eq("t5_perr_rst", {63'd0, a_perr}, 64'd0);
    check_eq("t5_cnt_rst", {48'd0, a_cnt}, 64'd0);
    tick();
    a_ack = 1'b0;
    check_eq("t5_rsh_stale", {63'd0, a_rsh}, 64'd0);
    check_eq("t5_busy_stale", {63'd0, a_busy}, 64'd0);

    // timeout of 4 cycles, late ack ignored
    b_fr = 1'b1; b_faddr = 32'h0000_0100;
    for (int i = 1; i <= 4; i++) begin
      tick();
      b_fr = 1'b0;
      check_eq("t6_mreq", {63'd0, b_mreq}, 64'd1);
    end
    tick();
    b_ack = 1'b1; b_rdata = 32'hCAFE_0000;
    check_eq("t6_mreq_drop", {63'd0, b_mreq}, 64'd0);
    check_eq("t6_rsh", {63'd0, b_rsh}, 64'd1);
    check_eq("t6_err", {63'd0, b_err}, 64'd1);
    check_eq("t6_inst", {32'd0, b_inst}, 64'd0);
    tick();
    check_eq("t6_late_rsh", {63'd0, b_rsh}, 64'd0);
    check_eq("t6_late_busy", {63'd0, b_busy}, 64'd0);
    tick();
    b_ack = 1'b0;
    check_eq("t6_late_rsh2", {63'd0, b_rsh}, 64'd0);
    check_eq("t6_cnt", {62'd0, b_cnt}, 64'd1);

    // four more fetches on the 2-bit counter: 5 total wraps to 1
    for (int i = 0; i < 4; i++) begin
      b_fr = 1'b1; b_faddr = 32'h0000_0202;
      tick();
      b_fr = 1'b0;
      check_eq("t7_rsh", {63'd0, b_rsh}, 64'd1);
      tick();
    end
    check_eq("t7_cnt_wrap", {62'd0, b_cnt}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
